apb_modport_bridge: RTL and testbench

// - AHB-Lite slave to APB master bridge; drives the APB side (Pselx/Penable/Pwrite/Paddr/Pwdata).
// - Samples AHB transfers and decodes four APB slaves from Haddr.
// - Returns read data / ready to the AHB master; one APB transfer in flight at a time.

---
 rtl/apb_modport_bridge.sv | 164 ++++++++++++++++
 tb/tb_apb_modport_bridge.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/apb_modport_bridge.sv
// AHB-Lite slave to APB master bridge with four 64 MB APB slaves behind BASE_ADDR.
// Optional macro BRIDGE_ERR_RESP_EN: out-of-range transfers get a two-cycle ERROR response.
module apb_modport_bridge #(
  parameter int                 ADDR_W        = 32,
  parameter int                 DATA_W        = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR     = 32'h8000_0000,
  parameter int                 SLV_SPAN_LOG2 = 26
) (
  input  logic              clk,
  input  logic              Hresetn,
  input  logic [1:0]        Htrans,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic [DATA_W-1:0] Hrdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  input  logic [DATA_W-1:0] Prdata,
  output logic [3:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata
);

`ifdef BRIDGE_ERR_RESP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_READ, S_RENABLE, S_WRITE, S_WENABLE, S_ERR1, S_ERR2
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_READ, S_RENABLE, S_WRITE, S_WENABLE
  } state_t;
`endif

  // Range compare is done one bit wider so a region ending at the top of memory still works.
  localparam logic [ADDR_W:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] RANGE_HI = RANGE_LO + ({{(ADDR_W-2){1'b0}}, 3'd4} << SLV_SPAN_LOG2);

  state_t            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        Pselx_q, Pselx_d;
  logic              Penable_q, Penable_d;
  logic              Pwrite_q, Pwrite_d;
  logic [ADDR_W-1:0] Paddr_q, Paddr_d;
  logic [DATA_W-1:0] Pwdata_q, Pwdata_d;
  logic              Hreadyout_q, Hreadyout_d;
  logic [1:0]        Hresp_q, Hresp_d;

  logic [1:0] slv_idx;
  logic [3:0] dec_sel;
  logic       in_range;
  logic       trans_active;
  logic       can_accept;
  logic       acc_ok;
  logic       acc_err;

  assign slv_idx = Haddr[SLV_SPAN_LOG2 +: 2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign dec_sel[gi] = (slv_idx == 2'(gi));
    end
  endgenerate

  assign in_range     = ({1'b0, Haddr} >= RANGE_LO) && ({1'b0, Haddr} < RANGE_HI);
  assign trans_active = (Htrans == 2'b10) || (Htrans == 2'b11);
  assign can_accept   = (state_q == S_IDLE) || (state_q == S_RENABLE) || (state_q == S_WENABLE);
  assign acc_ok       = can_accept && Hreadyout_q && Hreadyin && trans_active && in_range;
  assign acc_err      = can_accept && Hreadyout_q && Hreadyin && trans_active && !in_range;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    Paddr_d     = Paddr_q;
    Pwrite_d    = Pwrite_q;
    Pwdata_d    = Pwdata_q;
    Pselx_d     = 4'b0000;
    Penable_d   = 1'b0;
    Hreadyout_d = 1'b1;
    Hresp_d     = 2'b00;

    case (state_q)
      S_WWAIT: state_d = S_WRITE;
      S_READ:  state_d = S_RENABLE;
      S_WRITE: state_d = S_WENABLE;
`ifdef BRIDGE_ERR_RESP_EN
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
`endif
      default: begin
        if (acc_ok) begin
          state_d = Hwrite ? S_WWAIT : S_READ;
`ifdef BRIDGE_ERR_RESP_EN
        end else if (acc_err) begin
          state_d = S_ERR1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // APB address/direction are captured once per transfer and then held.
    if (acc_ok) begin
      sel_d    = dec_sel;
      Paddr_d  = Haddr;
      Pwrite_d = Hwrite;
    end
    if (state_q == S_WWAIT) begin
      Pwdata_d = Hwdata;
    end

    // Outputs are a function of the state being entered, so they come straight from flops.
    case (state_d)
      S_WWAIT:   Hreadyout_d = 1'b0;
      S_READ:    begin Pselx_d = sel_d; Hreadyout_d = 1'b0; end
      S_RENABLE: begin Pselx_d = sel_d; Penable_d = 1'b1; end
      S_WRITE:   begin Pselx_d = sel_d; Hreadyout_d = 1'b0; end
      S_WENABLE: begin Pselx_d = sel_d; Penable_d = 1'b1; end
`ifdef BRIDGE_ERR_RESP_EN
      S_ERR1:    begin Hreadyout_d = 1'b0; Hresp_d = 2'b01; end
      S_ERR2:    Hresp_d = 2'b01;
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= S_IDLE;
      sel_q       <= 4'b0000;
      Pselx_q     <= 4'b0000;
      Penable_q   <= 1'b0;
      Pwrite_q    <= 1'b0;
      Paddr_q     <= '0;
      Pwdata_q    <= '0;
      Hreadyout_q <= 1'b1;
      Hresp_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      Pselx_q     <= Pselx_d;
      Penable_q   <= Penable_d;
      Pwrite_q    <= Pwrite_d;
      Paddr_q     <= Paddr_d;
      Pwdata_q    <= Pwdata_d;
      Hreadyout_q <= Hreadyout_d;
      Hresp_q     <= Hresp_d;
    end
  end

  assign Pselx     = Pselx_q;
  assign Penable   = Penable_q;
  assign Pwrite    = Pwrite_q;
  assign Paddr     = Paddr_q;
  assign Pwdata    = Pwdata_q;
  assign Hreadyout = Hreadyout_q;
  assign Hresp     = Hresp_q;
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_apb_modport_bridge.sv
// Table-driven bench for apb_modport_bridge: per-cycle vectors plus an async-reset-mid-write sequence.
module tb_apb_modport_bridge;

  logic        clk;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic        Hreadyin;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Prdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  apb_modport_bridge dut (
    .clk(clk), .Hresetn(Hresetn), .Htrans(Htrans), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Prdata(Prdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .Pwdata(Pwdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BRIDGE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic        rdyin;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [3:0]  e_sel;
    logic        e_en;
    logic        e_pw;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic        e_rdy;
    logic [1:0]  e_resp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input logic [1:0] trans, input logic wr, input logic rdyin,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] prdata, input logic [3:0] e_sel,
                              input logic e_en, input logic e_pw, input logic [31:0] e_paddr,
                              input logic [31:0] e_pwdata, input logic e_rdy,
                              input logic [1:0] e_resp);
    vec_t v;
    v.trans = trans; v.wr = wr; v.rdyin = rdyin; v.addr = addr; v.wdata = wdata;
    v.prdata = prdata; v.e_sel = e_sel; v.e_en = e_en; v.e_pw = e_pw; v.e_paddr = e_paddr;
    v.e_pwdata = e_pwdata; v.e_rdy = e_rdy; v.e_resp = e_resp;
    return v;
  endfunction

  task automatic check_outputs(input string name, input logic [3:0] e_sel, input logic e_en,
                               input logic e_pw, input logic [31:0] e_paddr,
                               input logic [31:0] e_pwdata, input logic e_rdy,
                               input logic [1:0] e_resp, input logic [31:0] e_rdata);
    n_vec++;
    if (Pselx !== e_sel || Penable !== e_en || Pwrite !== e_pw || Paddr !== e_paddr ||
        Pwdata !== e_pwdata || Hreadyout !== e_rdy || Hresp !== e_resp || Hrdata !== e_rdata) begin
      n_bad++;
      $display("FAIL %s: got sel=%b en=%b pw=%b paddr=%h pwdata=%h rdy=%b resp=%b rdata=%h, want sel=%b en=%b pw=%b paddr=%h pwdata=%h rdy=%b resp=%b rdata=%h",
               name, Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp, Hrdata,
               e_sel, e_en, e_pw, e_paddr, e_pwdata, e_rdy, e_resp, e_rdata);
    end else begin
      $display("ok   %s: sel=%b en=%b pw=%b paddr=%h pwdata=%h rdy=%b resp=%b rdata=%h",
               name, Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp, Hrdata);
    end
  endtask

  task automatic drive(input logic [1:0] trans, input logic wr, input logic rdyin,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] prdata);
    Htrans = trans; Hwrite = wr; Hreadyin = rdyin; Haddr = addr; Hwdata = wdata; Prdata = prdata;
  endtask

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [31:0] WD = 32'hA5A5_0001;
  localparam logic [31:0] RD = 32'h1234_5678;

  initial begin
    n_vec = 0;
    n_bad = 0;
    drive(T_IDLE, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    Hresetn = 1'b0;
    #12;
    check_outputs("reset_state", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0);

    // Each row: inputs driven before a posedge, outputs expected just after it.
    // single write to slave 1
    vecs.push_back(mk(T_NSEQ, 1, 1, 32'h8400_0010, 32'h0, 32'h0, 4'b0000, 0, 1, 32'h8400_0010, 32'h0, 0, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, WD,    32'h0, 4'b0010, 0, 1, 32'h8400_0010, WD, 0, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0010, 1, 1, 32'h8400_0010, WD, 1, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 1, 32'h8400_0010, WD, 1, 2'b00));
    // single read from slave 3
    vecs.push_back(mk(T_NSEQ, 0, 1, 32'h8C00_0004, 32'h0, 32'h0, 4'b1000, 0, 0, 32'h8C00_0004, WD, 0, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, RD,    4'b1000, 1, 0, 32'h8C00_0004, WD, 1, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8C00_0004, WD, 1, 2'b00));
    // back-to-back NONSEQ then SEQ read on slave 0
    vecs.push_back(mk(T_NSEQ, 0, 1, 32'h8000_0000, 32'h0, 32'h0, 4'b0001, 0, 0, 32'h8000_0000, WD, 0, 2'b00));
    vecs.push_back(mk(T_NSEQ, 0, 1, 32'h8000_0000, 32'h0, 32'h11, 4'b0001, 1, 0, 32'h8000_0000, WD, 1, 2'b00));
    vecs.push_back(mk(T_SEQ,  0, 1, 32'h8000_0004, 32'h0, 32'h0, 4'b0001, 0, 0, 32'h8000_0004, WD, 0, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h22,  4'b0001, 1, 0, 32'h8000_0004, WD, 1, 2'b00));
    // ignored transfers at slave 2
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h8800_0000, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, 2'b00));
    vecs.push_back(mk(T_BUSY, 0, 1, 32'h8800_0000, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, 2'b00));
    vecs.push_back(mk(T_NSEQ, 0, 0, 32'h8800_0000, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, 2'b00));
    // out-of-range above and below the region
    vecs.push_back(mk(T_NSEQ, 0, 1, 32'h9000_0000, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, ERR_EN ? 1'b0 : 1'b1, ERR_EN ? 2'b01 : 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, ERR_EN ? 2'b01 : 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, 2'b00));
    vecs.push_back(mk(T_NSEQ, 1, 1, 32'h7FFF_FFFC, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, ERR_EN ? 1'b0 : 1'b1, ERR_EN ? 2'b01 : 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, ERR_EN ? 2'b01 : 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0000, 0, 0, 32'h8000_0004, WD, 1, 2'b00));
    // write to slave 2 right after reset-free idle
    vecs.push_back(mk(T_NSEQ, 1, 1, 32'h8800_0100, 32'h0, 32'h0, 4'b0000, 0, 1, 32'h8800_0100, WD, 0, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'hDEAD_BEEF, 32'h0, 4'b0100, 0, 1, 32'h8800_0100, 32'hDEAD_BEEF, 0, 2'b00));
    vecs.push_back(mk(T_IDLE, 0, 1, 32'h0, 32'h0, 32'h0, 4'b0100, 1, 1, 32'h8800_0100, 32'hDEAD_BEEF, 1, 2'b00));

    @(negedge clk);
    Hresetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].trans, vecs[i].wr, vecs[i].rdyin, vecs[i].addr, vecs[i].wdata, vecs[i].prdata);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_en, vecs[i].e_pw,
                    vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_rdy, vecs[i].e_resp,
                    vecs[i].prdata);
    end

    // Asynchronous reset asserted while the bridge sits in the WRITE setup phase.
    @(negedge clk);
    drive(T_NSEQ, 1'b1, 1'b1, 32'h8000_0020, 32'h0, 32'h0);
    @(negedge clk);
    drive(T_IDLE, 1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 32'h0);
    @(posedge clk);
    #1;
    check_outputs("pre_reset_write", 4'b0001, 1'b0, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0);
    #2;
    Hresetn = 1'b0;
    #1;
    check_outputs("reset_mid_write", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    check_outputs("reset_held", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00, 32'h0);
    @(negedge clk);
    Hresetn = 1'b1;
    drive(T_NSEQ, 1'b0, 1'b1, 32'h8400_0008, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check_outputs("read_after_reset", 4'b0010, 1'b0, 1'b0, 32'h8400_0008, 32'h0, 1'b0, 2'b00, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
